// File: rtl/spi_frame_parser.sv
// spi_frame_parser
//  Framing stage between the SPI slave byte stream and the BSRAM image buffer.
//  Validates CS-delimited packets (SYNC, LEN_HI, LEN_LO, LEN payload bytes, CHK),
//  writes payload bytes to the buffer from address 0 and reports done/error per frame.
// Ports
//  clk_i          system clock
//  rst_i          synchronous active-high reset
//  cs_n_i         synchronised chip select, low = packet open
//  rx_data_i      byte from the SPI slave
//  rx_valid_i     single-cycle byte strobe
//  rx_ready_o     byte accept (0 in reset, 1 otherwise)
//  wr_en_o        BRAM write strobe
//  wr_addr_o      BRAM write address
//  wr_data_o      BRAM write data
//  frame_done_o   1-cycle pulse, packet passed all checks
//  frame_err_o    1-cycle pulse, packet rejected
//  err_code_o     reject reason: 0 sync, 1 length, 2 checksum, 3 truncated
//  frame_len_o    payload length of the last good frame
//  frame_count_o  good-frame counter, wraps
//  busy_o         parser is not idle
module spi_frame_parser #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned MAX_LEN    = 32768,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cs_n_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  frame_done_o,
  output logic                  frame_err_o,
  output logic [1:0]            err_code_o,
  output logic [15:0]           frame_len_o,
  output logic [7:0]            frame_count_o,
  output logic                  busy_o
);

  // 17 bits so that MAX_LEN = 65536 would still compare correctly
  localparam logic [16:0] MaxLenW = 17'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHECK, S_WAIT_CS
  } state_e;

  state_e                state_q;
  logic                  rx_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic                  frame_done_q;
  logic                  frame_err_q;
  logic [1:0]            err_code_q;
  logic [15:0]           frame_len_q;
  logic [7:0]            frame_count_q;
  logic [7:0]            len_hi_q;
  logic [15:0]           len_q;
  logic [15:0]           idx_q;
  logic [7:0]            sum_q;

  logic [15:0]           idx_d;
  logic [7:0]            sum_d;
  logic [15:0]           len_c;
  logic                  len_bad_c;
  logic                  pkt_open_c;

  assign idx_d      = idx_q + 16'd1;
  assign sum_d      = sum_q + rx_data_i;
  assign len_c      = {len_hi_q, rx_data_i};
  assign len_bad_c  = (len_c == 16'd0) || ({1'b0, len_c} > MaxLenW);
  // cs_n rising in these states means the packet was cut short
  assign pkt_open_c = (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);

  // Framing FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      rx_ready_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'd0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      frame_len_q   <= 16'd0;
      frame_count_q <= 8'd0;
      len_hi_q      <= 8'd0;
      len_q         <= 16'd0;
      idx_q         <= 16'd0;
      sum_q         <= 8'd0;
    end else begin
      rx_ready_q   <= 1'b1;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (cs_n_i) begin
        // chip select closes the packet; a same-cycle byte is dropped
        state_q <= S_IDLE;
        if (pkt_open_c) begin
          frame_err_q <= 1'b1;
          err_code_q  <= 2'd3;
        end
      end else if (rx_valid_i) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data_i == SYNC_BYTE) begin
              state_q <= S_LEN_H;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd0;
              state_q     <= S_WAIT_CS;
            end
          end
          S_LEN_H: begin
            len_hi_q <= rx_data_i;
            state_q  <= S_LEN_L;
          end
          S_LEN_L: begin
            if (len_bad_c) begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd1;
              state_q     <= S_WAIT_CS;
            end else begin
              len_q   <= len_c;
              idx_q   <= 16'd0;
              sum_q   <= 8'd0;
              state_q <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q[ADDR_WIDTH-1:0];
            wr_data_q <= rx_data_i;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            if (idx_q == len_q - 16'd1) state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (rx_data_i == sum_q) begin
              frame_done_q  <= 1'b1;
              frame_len_q   <= len_q;
              frame_count_q <= frame_count_q + 8'd1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd2;
            end
            state_q <= S_WAIT_CS;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign rx_ready_o    = rx_ready_q;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign frame_done_o  = frame_done_q;
  assign frame_err_o   = frame_err_q;
  assign err_code_o    = err_code_q;
  assign frame_len_o   = frame_len_q;
  assign frame_count_o = frame_count_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_frame_parser.sv
// tb_spi_frame_parser
//  Self-checking bench for spi_frame_parser: table vectors, directed corner
//  sequences and random packets scored against a packet-level reference model.
module tb_spi_frame_parser;

  localparam int unsigned AW   = 15;
  localparam int          MAXL = 32768;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nhdr;
    int         npay;
    bit         send_chk;
    logic [7:0] delta;
    bit         close_valid;
    bit         exp_done;
    logic [1:0] exp_code;
    int         exp_nwr;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          cs_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_done;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [15:0]   frame_len;
  logic [7:0]    frame_count;
  logic          busy;

  spi_frame_parser #(.ADDR_WIDTH(AW), .MAX_LEN(MAXL), .SYNC_BYTE(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .cs_n_i(cs_n), .rx_data_i(rx_data),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .frame_done_o(frame_done),
    .frame_err_o(frame_err), .err_code_o(err_code), .frame_len_o(frame_len),
    .frame_count_o(frame_count), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed BRAM writes {addr, data} and cumulative pulse counts
  logic [AW+7:0] obs_w[$];
  int tot_done = 0;
  int tot_err  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) obs_w.push_back({wr_addr, wr_data});
      if (frame_done) tot_done++;
      if (frame_err) tot_err++;
    end
  end

  // Reference-model persistent outputs
  logic [7:0]  m_count = 8'd0;
  logic [15:0] m_len   = 16'd0;
  logic [1:0]  m_code  = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one CS-delimited packet and score it against the packet-level rules
  task automatic run_packet(input bq_t pkt, input bit close_valid, input int max_gap,
                            output int o_nwr, output int o_done, output int o_err);
    int n, base_w, base_d, base_e, dk, len, wr_lo, wr_hi, nw;
    bit exp_done, exp_err, ok, busy_ok;
    logic [1:0] code;
    logic [7:0] s;
    n = pkt.size();
    base_w = obs_w.size(); base_d = tot_done; base_e = tot_err;
    exp_done = 0; exp_err = 0; dk = -1; code = m_code; len = 0; wr_lo = 0; wr_hi = 0;
    if (n == 0) begin
      // nothing sent, nothing expected
    end else if (pkt[0] != 8'hA5) begin
      exp_err = 1; code = 2'd0; dk = 0;
    end else if (n < 3) begin
      exp_err = 1; code = 2'd3;
    end else begin
      len = int'({pkt[1], pkt[2]});
      if (len == 0 || len > MAXL) begin
        exp_err = 1; code = 2'd1; dk = 2;
      end else begin
        wr_lo = 3;
        wr_hi = (n < 3 + len) ? n : 3 + len;
        if (n < 4 + len) begin
          exp_err = 1; code = 2'd3;
        end else begin
          s = 8'd0;
          for (int i = 3; i < 3 + len; i++) s = s + pkt[i];
          dk = 3 + len;
          if (pkt[dk] == s) exp_done = 1;
          else begin exp_err = 1; code = 2'd2; end
        end
      end
    end

    busy_ok = 1;
    cs_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin rx_valid = 1'b0; tick(); end
      rx_valid = 1'b1; rx_data = pkt[k];
      tick();
      rx_valid = 1'b0;
      if (!busy) busy_ok = 0;
      if (k == dk) chk("pulse_timing", exp_done ? {frame_done, frame_err} : {frame_err, frame_done}, 2'b10);
    end
    cs_n = 1'b1; rx_valid = close_valid; rx_data = 8'($urandom);
    tick();
    rx_valid = 1'b0;
    if (exp_err && dk < 0) begin
      chk("trunc_timing", frame_err, 1);
      chk("trunc_code", err_code, 3);
    end
    tick(); tick();

    if (exp_done) begin m_count = m_count + 8'd1; m_len = 16'(len); end
    if (exp_err) m_code = code;

    nw = obs_w.size() - base_w;
    chk("wr_count", nw, wr_hi - wr_lo);
    ok = 1;
    for (int j = 0; j < nw && j < wr_hi - wr_lo; j++)
      if (obs_w[base_w + j] !== {AW'(j), pkt[wr_lo + j]}) ok = 0;
    chk("wr_content", ok, 1);
    chk("done_pulses", tot_done - base_d, exp_done);
    chk("err_pulses", tot_err - base_e, exp_err);
    chk("err_code", err_code, m_code);
    chk("frame_len", frame_len, m_len);
    chk("frame_count", frame_count, m_count);
    chk("busy_open", busy_ok, 1);
    chk("busy_closed", busy, 0);
    o_nwr = nw; o_done = tot_done - base_d; o_err = tot_err - base_e;
  endtask

  task automatic build_vec(input vec_t v, output bq_t pkt);
    logic [7:0] s;
    pkt = {};
    if (v.nhdr > 0) pkt.push_back(v.b0);
    if (v.nhdr > 1) pkt.push_back(v.b1);
    if (v.nhdr > 2) pkt.push_back(v.b2);
    s = 8'd0;
    for (int i = 0; i < v.npay; i++) begin
      pkt.push_back(8'((i + 1) * 16));
      s = s + 8'((i + 1) * 16);
    end
    if (v.send_chk) pkt.push_back(s + v.delta);
  endtask

  task automatic rand_good(input int maxlen, output bq_t pkt);
    int l;
    logic [7:0] s, b;
    l = $urandom_range(maxlen, 1);
    pkt = {8'hA5, 8'(l >> 8), 8'(l)};
    s = 8'd0;
    for (int i = 0; i < l; i++) begin
      b = 8'($urandom);
      pkt.push_back(b);
      s = s + b;
    end
    pkt.push_back(s);
  endtask

  vec_t tbl[8];

  initial begin
    bq_t pkt;
    int nwr, nd, ne, sel, l, cut, n_before_d, n_before_e;
    logic [7:0] s;

    tbl[0] = '{8'hA5, 8'h00, 8'h04, 3, 4, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 4};
    tbl[1] = '{8'hA5, 8'h00, 8'h04, 3, 4, 1'b1, 8'h01, 1'b0, 1'b0, 2'd2, 4};
    tbl[2] = '{8'h5A, 8'h00, 8'h04, 3, 4, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 0};
    tbl[3] = '{8'hA5, 8'h00, 8'h00, 3, 2, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 0};
    tbl[4] = '{8'hA5, 8'h80, 8'h01, 3, 2, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 0};
    tbl[5] = '{8'hA5, 8'h00, 8'h04, 3, 2, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 2};
    tbl[6] = '{8'hA5, 8'h00, 8'h01, 3, 1, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 1};
    tbl[7] = '{8'hA5, 8'h00, 8'h00, 2, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 0};

    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) tick();
    chk("reset_outputs", {31'd0, rx_ready, wr_en, frame_done, frame_err, busy}, 0);
    chk("reset_regs", {frame_len, frame_count, err_code, 6'd0}, 0);
    rst = 1'b0;
    tick();
    chk("rx_ready_after_reset", rx_ready, 1);

    // Table vectors
    for (int t = 0; t < 8; t++) begin
      build_vec(tbl[t], pkt);
      run_packet(pkt, tbl[t].close_valid, 1, nwr, nd, ne);
      chk("tbl_done", nd, tbl[t].exp_done);
      chk("tbl_err", ne, !tbl[t].exp_done);
      chk("tbl_nwr", nwr, tbl[t].exp_nwr);
      if (!tbl[t].exp_done) chk("tbl_code", err_code, tbl[t].exp_code);
      if (t == 0) begin
        chk("tbl_first_len", frame_len, 16'd4);
        chk("tbl_first_count", frame_count, 8'd1);
      end
    end

    // Bad sync followed by 100 ignored bytes
    pkt = {8'h5A};
    for (int i = 0; i < 100; i++) pkt.push_back(8'($urandom));
    run_packet(pkt, 1'b0, 0, nwr, nd, ne);
    chk("badsync_nwr", nwr, 0);

    // Maximum length packet fills the whole buffer
    pkt = {8'hA5, 8'h80, 8'h00};
    s = 8'd0;
    for (int i = 0; i < MAXL; i++) begin
      pkt.push_back(8'($urandom));
      s = s + pkt[3 + i];
    end
    pkt.push_back(s);
    run_packet(pkt, 1'b0, 0, nwr, nd, ne);
    chk("maxlen_nwr", nwr, MAXL);
    chk("maxlen_done", nd, 1);

    // Reset in the middle of a payload
    cs_n = 1'b0;
    pkt = {8'hA5, 8'h00, 8'h04, 8'h10, 8'h20};
    foreach (pkt[i]) begin rx_valid = 1'b1; rx_data = pkt[i]; tick(); end
    rx_valid = 1'b0;
    n_before_d = tot_done; n_before_e = tot_err;
    rst = 1'b1;
    tick();
    chk("midreset_outputs", {wr_en, frame_done, frame_err, busy, err_code, frame_count, frame_len}, 0);
    tick();
    rst = 1'b0; cs_n = 1'b1;
    repeat (3) tick();
    chk("midreset_no_pulse", (tot_done - n_before_d) + (tot_err - n_before_e), 0);
    chk("midreset_idle", busy, 0);
    m_count = 8'd0; m_len = 16'd0; m_code = 2'd0;

    // 256 good frames wrap the counter
    for (int f = 0; f < 256; f++) begin
      rand_good(4, pkt);
      run_packet(pkt, 1'($urandom), 0, nwr, nd, ne);
    end
    chk("count_wrap", frame_count, 8'd0);

    // Random packets against the reference model
    for (int r = 0; r < 200; r++) begin
      sel = $urandom_range(9, 0);
      if (sel < 5) begin
        rand_good(6, pkt);
        if ($urandom_range(1, 0) == 1) pkt[pkt.size() - 1] = pkt[pkt.size() - 1] + 8'(1 + $urandom_range(254, 0));
      end else if (sel == 5) begin
        pkt = {8'($urandom), 8'($urandom), 8'($urandom)};
      end else if (sel == 6) begin
        l = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(65535, 32769);
        pkt = {8'hA5, 8'(l >> 8), 8'(l), 8'($urandom), 8'($urandom)};
      end else begin
        rand_good(6, pkt);
      end
      if ($urandom_range(3, 0) == 0) begin
        cut = $urandom_range(pkt.size() - 1, 0);
        while (pkt.size() > cut) void'(pkt.pop_back());
      end else if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) pkt.push_back(8'($urandom));
      end
      run_packet(pkt, 1'($urandom), 2, nwr, nd, ne);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
